// File: rtl/input_logic_pkg.sv
// Shared constants and types for the eFPGA input conditioning tile:
// configuration word layout, field positions and vertical-select decoding.
package input_logic_pkg;

    localparam int CFG_WORDS = 7;
    localparam int WORD_W    = 32;
    localparam int NUM_VSEL  = 8;

    // Word positions inside the configuration chain (cfg[0] is loaded last).
    localparam int CFG_CTRL  = 0;
    localparam int CFG_INV   = 1;
    localparam int CFG_REG   = 2;
    localparam int CFG_PULSE = 3;
    localparam int CFG_OE    = 4;
    localparam int CFG_VSEL0 = 5;
    localparam int CFG_VSEL1 = 6;

    localparam int GEN_BIT = 31;
    localparam int VEN_LSB = 16;
    localparam int SEL_W   = 5;

    typedef logic [SEL_W-1:0] vsel_t;

    // sel0..sel5 live in the low word, sel6/sel7 in the bottom of the high word.
    function automatic vsel_t vsel_of(input logic [WORD_W-1:0] w_lo,
                                      input logic [WORD_W-1:0] w_hi,
                                      input int unsigned       j);
        if (j < 6) return w_lo[SEL_W*j +: SEL_W];
        else       return w_hi[SEL_W*(j-6) +: SEL_W];
    endfunction

endpackage

// File: rtl/input_logic_cfg_chain.sv
// Generic N-word x 32-bit configuration shift register with async clear.
// All words are visible in parallel; the oldest word leaves on prog_o.
module input_logic_cfg_chain
    import input_logic_pkg::*;
#(
    parameter int N = CFG_WORDS
) (
    input  logic                       clk,
    input  logic                       nres,
    input  logic                       shft,
    input  logic [WORD_W-1:0]          prog_i,
    output logic [N-1:0][WORD_W-1:0]   words,
    output logic [WORD_W-1:0]          prog_o
);

    // NOTE: the chain is cleared on reset, unlike a plain memory, because
    // every output must read 0 until the fabric is reprogrammed.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            words <= '0;
        end else if (shft) begin
            // NOTE: non-blocking so every word moves from its pre-edge neighbour.
            words[0] <= prog_i;
            for (int k = 1; k < N; k++) begin
                words[k] <= words[k-1];
            end
        end
    end

    assign prog_o = words[N-1];

endmodule

// File: rtl/input_logic.sv
// eFPGA input tile: per-bit inversion, optional registering and rising-edge
// pulse shaping, driving the horizontal and vertical connection-block buses.
module input_logic
    import input_logic_pkg::*;
(
    input  logic                clk,
    input  logic                nres,
    input  logic [WORD_W-1:0]   prog_i,
    input  logic                prog_shft,
    output logic [WORD_W-1:0]   prog_o,
    input  logic [WORD_W-1:0]   data_in,
    input  logic                en,
    output logic [WORD_W-1:0]   data_oCB,
    output logic [NUM_VSEL-1:0] data_oCBV
);

    logic [CFG_WORDS-1:0][WORD_W-1:0] cfg;

    input_logic_cfg_chain #(.N(CFG_WORDS)) u_cfg_chain (
        .clk    (clk),
        .nres   (nres),
        .shft   (prog_shft),
        .prog_i (prog_i),
        .words  (cfg),
        .prog_o (prog_o)
    );

    logic [WORD_W-1:0]   inv_m, reg_m, pulse_m, oe_m;
    logic [NUM_VSEL-1:0] ven_m;
    logic                gate;

    assign inv_m   = cfg[CFG_INV];
    assign reg_m   = cfg[CFG_REG];
    assign pulse_m = cfg[CFG_PULSE];
    assign oe_m    = cfg[CFG_OE];
    assign ven_m   = cfg[CFG_VSEL1][VEN_LSB +: NUM_VSEL];

    // Outputs are forced low while the chain is moving so half-loaded
    // configurations never reach the routing fabric.
    assign gate = cfg[CFG_CTRL][GEN_BIT] & ~prog_shft;

    logic [WORD_W-1:0] cond, sample_r, sample_p, value;

    assign cond = data_in ^ inv_m;

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            sample_r <= '0;
            sample_p <= '0;
        end else if (en) begin
            sample_r <= cond;
            sample_p <= sample_r;
        end
    end

    // PULSE only matters on registered bits; it masks the delayed copy.
    assign value = (cond & ~reg_m) | (sample_r & reg_m & ~(pulse_m & sample_p));

    assign data_oCB = {WORD_W{gate}} & oe_m & value;

    always_comb begin
        // NOTE: default first so no path through the loop can infer a latch.
        data_oCBV = '0;
        for (int unsigned j = 0; j < NUM_VSEL; j++) begin
            data_oCBV[j] = gate & ven_m[j]
                         & value[vsel_of(cfg[CFG_VSEL0], cfg[CFG_VSEL1], j)];
        end
    end

    // Reserved configuration bits have no function.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg[CFG_CTRL][GEN_BIT-1:0],
                               cfg[CFG_VSEL0][WORD_W-1:6*SEL_W],
                               cfg[CFG_VSEL1][WORD_W-1:VEN_LSB+NUM_VSEL],
                               cfg[CFG_VSEL1][VEN_LSB-1:2*SEL_W]};

endmodule

// File: tb/tb_input_logic.sv
// Scoreboard bench for input_logic: stimulus pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_input_logic;

    logic        clk = 1'b0;
    logic        nres;
    logic [31:0] prog_i;
    logic        prog_shft;
    logic [31:0] prog_o;
    logic [31:0] data_in;
    logic        en;
    logic [31:0] data_oCB;
    logic [7:0]  data_oCBV;

    input_logic dut (
        .clk       (clk),
        .nres      (nres),
        .prog_i    (prog_i),
        .prog_shft (prog_shft),
        .prog_o    (prog_o),
        .data_in   (data_in),
        .en        (en),
        .data_oCB  (data_oCB),
        .data_oCBV (data_oCBV)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] cb;
        logic [7:0]  cbv;
        logic [31:0] po;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: configuration words, last sample, sample before that.
    logic [31:0] m_cfg [7];
    logic [31:0] m_r, m_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 7; k++) m_cfg[k] = '0;
        m_r = '0;
        m_p = '0;
    endfunction

    function automatic exp_t model_out(input string name);
        exp_t        e;
        logic [31:0] v;
        logic        g;
        int          sel;
        g = m_cfg[0][31] && !prog_shft && nres;
        for (int i = 0; i < 32; i++) begin
            logic c;
            c = data_in[i] ^ m_cfg[1][i];
            if (!m_cfg[2][i])      v[i] = c;
            else if (!m_cfg[3][i]) v[i] = m_r[i];
            else                   v[i] = m_r[i] && !m_p[i];
        end
        e.name = name;
        e.cb   = g ? (v & m_cfg[4]) : 32'h0;
        for (int j = 0; j < 8; j++) begin
            if (j < 6) sel = int'((m_cfg[5] >> (5 * j)) & 32'd31);
            else       sel = int'((m_cfg[6] >> (5 * (j - 6))) & 32'd31);
            e.cbv[j] = g && m_cfg[6][16 + j] && v[sel];
        end
        e.po = m_cfg[6];
        return e;
    endfunction

    // Push the expectation for the current inputs, then advance one edge.
    task automatic step(input string name);
        logic [31:0] c_now, pi_now;
        logic        en_now, sh_now;
        sb.push_back(model_out(name));
        c_now  = data_in ^ m_cfg[1];
        pi_now = prog_i;
        en_now = en;
        sh_now = prog_shft;
        @(posedge clk);
        if (nres) begin
            if (en_now) begin
                m_p = m_r;
                m_r = c_now;
            end
            if (sh_now) begin
                for (int k = 6; k > 0; k--) m_cfg[k] = m_cfg[k-1];
                m_cfg[0] = pi_now;
            end
        end
        #1;
    endtask

    task automatic program_cfg(input logic [6:0][31:0] w);
        prog_shft = 1'b1;
        for (int k = 6; k >= 0; k--) begin
            prog_i  = w[k];
            en      = 1'($urandom);
            data_in = $urandom;
            step("shift_gate");
        end
        prog_shft = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".cb"},  data_oCB,          e.cb);
            check({e.name, ".cbv"}, {24'h0, data_oCBV}, {24'h0, e.cbv});
            check({e.name, ".po"},  prog_o,            e.po);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0][31:0] w;
        model_reset();
        nres      = 1'b0;
        prog_shft = 1'b0;
        prog_i    = '0;
        en        = 1'b0;
        data_in   = 32'h9696_9696;
        @(posedge clk);
        #1;

        // Reset held, then released with no programming: GEN=0 keeps outputs low.
        step("reset_hold");
        step("reset_hold");
        nres = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = $urandom;
            en      = 1'($urandom);
            step("post_reset");
        end

        // Chain load from the plan; outputs gated while shifting.
        w[6] = 32'h8765_4321; w[5] = 32'hFEDC_AB98; w[4] = 32'hFEDC_AB98;
        w[3] = 32'h8765_4321; w[2] = 32'hFEDC_AB98; w[1] = 32'h8765_4321;
        w[0] = 32'h8000_0000;
        program_cfg(w);
        for (int i = 0; i < 4; i++) begin
            data_in = $urandom;
            en      = 1'($urandom);
            step("chain_run");
        end

        // Combinational inversion path.
        w = '0;
        w[0] = 32'h8000_0000; w[1] = 32'hFFFF_FFFF; w[4] = 32'hFFFF_FFFF;
        program_cfg(w);
        en      = 1'b0;
        data_in = 32'h9696_9696;
        step("comb_inv");
        for (int i = 0; i < 4; i++) begin
            data_in = $urandom;
            step("comb_rand");
        end

        // Registered path: holds with en=0, follows one edge after en=1.
        w = '0;
        w[0] = 32'h8000_0000; w[2] = 32'hFFFF_FFFF; w[4] = 32'hFFFF_FFFF;
        program_cfg(w);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = $urandom;
            step("reg_hold");
        end
        en      = 1'b1;
        data_in = 32'hA5C3_0F81;
        step("reg_sample");
        en = 1'b0;
        step("reg_visible");
        step("reg_visible");

        // Pulse on bit 0: single-cycle high after a 0->1 input transition.
        w = '0;
        w[0] = 32'h8000_0000; w[2] = 32'h1; w[3] = 32'h1; w[4] = 32'hFFFF_FFFF;
        program_cfg(w);
        en      = 1'b1;
        data_in = 32'h0;
        step("pulse_low");
        step("pulse_low");
        data_in = 32'h1;
        for (int i = 0; i < 5; i++) step("pulse_edge");

        // Vertical selects: sel0=31, sel7=0, VEN=0x81.
        w = '0;
        w[0] = 32'h8000_0000; w[5] = 32'h0000_001F; w[6] = 32'h0081_0000;
        program_cfg(w);
        en      = 1'b0;
        data_in = 32'h8000_0000;
        step("vert_sel0");
        data_in = 32'h0000_0001;
        step("vert_sel7");

        // Randomised config and traffic, including shifting with en=1.
        for (int k = 0; k < 7; k++) w[k] = $urandom;
        w[0][31] = 1'b1;
        program_cfg(w);
        for (int i = 0; i < 300; i++) begin
            data_in   = $urandom;
            en        = 1'($urandom);
            prog_shft = ($urandom_range(0, 7) == 0);
            prog_i    = $urandom | 32'h8000_0000;
            step("random");
        end
        prog_shft = 1'b0;

        // Asynchronous reset mid-shift clears everything at once.
        prog_shft = 1'b1;
        prog_i    = $urandom;
        step("pre_abort");
        nres = 1'b0;
        model_reset();
        step("reset_abort");
        nres      = 1'b1;
        prog_shft = 1'b0;
        data_in   = $urandom;
        step("after_abort");

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
